// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - frame-buffer geometry, pixel/address types and arbiter states
package vga_pkg;

   localparam int H_RES  = 640;
   localparam int V_RES  = 480;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 12;

   typedef logic [DATA_W-1:0] pixel_t;
   typedef logic [ADDR_W-1:0] vaddr_t;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// rtl/vram_write_arbiter_if.sv - packed pixel-writer request bus shared by all requesters
interface vram_write_arbiter_if
   import vga_pkg::*;
#(
   parameter int N_REQ = 3
);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;

   modport master (
      output req_valid,
      output req_last,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_last,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the search at a given index
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [N_REQ-1:0] pick_oh,
   output logic [IDX_W-1:0] pick_idx
);

   always_comb begin
      logic found;
      int   j;
      pick_oh  = '0;
      pick_idx = '0;
      found    = 1'b0;
      j        = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(start) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[j]) begin
            found      = 1'b1;
            pick_oh[j] = 1'b1;
            pick_idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - round-robin, burst-locked arbiter for the VRAM write port
module vram_write_arbiter
   import vga_pkg::*;
#(
   parameter int N_REQ       = 3,
   parameter int MAX_BURST   = 64,
   parameter int GATE_VBLANK = 1
) (
   input  logic               CLOCK_50,
   input  logic               RESET_N,
   input  logic               vblank,
   vram_write_arbiter_if.slave bus,
   output logic               mem_we,
   output vaddr_t             mem_addr,
   output pixel_t             mem_data,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               addr_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);
   // One extra bit so a frame that exactly fills the address space still compares correctly.
   localparam logic [ADDR_W:0]  PIX_LIMIT = (ADDR_W + 1)'(H_RES * V_RES);

   state_t             state;
   logic [IDX_W-1:0]   rr;
   logic [IDX_W-1:0]   grant_idx;
   logic [CNT_W-1:0]   beat_cnt;

   logic               allow;
   logic [N_REQ-1:0]   ready;
   logic               hs;
   logic               hs_last;
   logic               in_range;
   vaddr_t             sel_addr;
   pixel_t             sel_data;
   logic [N_REQ-1:0]   pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   rr_next;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req      (bus.req_valid),
      .start    (rr),
      .pick_oh  (pick_oh),
      .pick_idx (pick_idx)
   );

   // Ready comes only from registered grant so requesters never see a valid->ready loop.
   assign allow         = (GATE_VBLANK == 0) | vblank;
   assign ready         = grant & {N_REQ{allow}};
   assign bus.req_ready = ready;

   assign hs       = |(bus.req_valid & ready);
   assign hs_last  = bus.req_last[grant_idx];
   assign sel_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign sel_data = bus.req_data[grant_idx*DATA_W +: DATA_W];
   assign in_range = {1'b0, sel_addr} < PIX_LIMIT;
   assign rr_next  = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
   assign busy     = (state == BURST);

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state     <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         rr        <= '0;
         beat_cnt  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         addr_err  <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  grant     <= pick_oh;
                  grant_idx <= pick_idx;
                  beat_cnt  <= '0;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (hs) begin
                  // Out-of-range beats are consumed but never reach the RAM.
                  if (in_range) begin
                     mem_we   <= 1'b1;
                     mem_addr <= sel_addr;
                     mem_data <= sel_data;
                  end else begin
                     addr_err <= 1'b1;
                  end
                  if (hs_last || beat_cnt == CNT_LAST) begin
                     state    <= IDLE;
                     grant    <= '0;
                     rr       <= rr_next;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb/tb_vram_write_arbiter.sv - directed self-checking bench for vram_write_arbiter
module tb_vram_write_arbiter;
   import vga_pkg::*;

   localparam int N_REQ = 3;

   logic             CLOCK_50 = 1'b0;
   logic             RESET_N  = 1'b0;
   logic             vblank   = 1'b1;
   logic             mem_we;
   vaddr_t           mem_addr;
   pixel_t           mem_data;
   logic [N_REQ-1:0] grant;
   logic             busy;
   logic             addr_err;

   int n_checks = 0;
   int n_fail   = 0;

   vram_write_arbiter_if #(.N_REQ(N_REQ)) bus ();

   vram_write_arbiter #(
      .N_REQ       (N_REQ),
      .MAX_BURST   (64),
      .GATE_VBLANK (1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .vblank   (vblank),
      .bus      (bus),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .grant    (grant),
      .busy     (busy),
      .addr_err (addr_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic l, input int a, input int d);
      bus.req_valid[i]                 = v;
      bus.req_last[i]                  = l;
      bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
      bus.req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
   endtask

   initial begin
      int n;
      int writes;

      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;

      // Reset state
      tick;
      tick;
      check_eq("rst_grant", 32'(grant), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_ready", 32'(bus.req_ready), 0);
      check_eq("rst_we", 32'(mem_we), 0);
      check_eq("rst_addr", 32'(mem_addr), 0);
      check_eq("rst_data", 32'(mem_data), 0);
      check_eq("rst_err", 32'(addr_err), 0);
      RESET_N = 1'b1;
      tick;

      // Single writer: 4 beats from requester 0
      set_req(0, 1'b1, 1'b0, 0, 'hF00);                      // cycle t
      tick;                                                  // t+1
      check_eq("w1_grant", 32'(grant), 1);
      check_eq("w1_ready", 32'(bus.req_ready), 1);
      check_eq("w1_busy", 32'(busy), 1);
      for (int b = 1; b <= 3; b++) begin
         tick;                                               // t+2..t+4
         check_eq("w1_we", 32'(mem_we), 1);
         check_eq("w1_addr", 32'(mem_addr), 32'(b - 1));
         check_eq("w1_data", 32'(mem_data), 'hF00);
         set_req(0, 1'b1, (b == 3), b, 'hF00);
      end
      tick;                                                  // t+5
      set_req(0, 1'b0, 1'b0, 0, 0);
      check_eq("w1_we_last", 32'(mem_we), 1);
      check_eq("w1_addr_last", 32'(mem_addr), 3);
      check_eq("w1_grant_rel", 32'(grant), 0);
      tick;                                                  // t+6
      check_eq("w1_busy_end", 32'(busy), 0);
      check_eq("w1_we_end", 32'(mem_we), 0);

      // Round-robin fairness with 1-beat bursts
      RESET_N = 1'b0;
      tick;
      RESET_N = 1'b1;
      for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b1, 100 + i, 'h111 * (i + 1));
      for (int k = 0; k < 6; k++) begin
         tick;
         check_eq("rr_grant", 32'(grant), 32'(1 << (k % 3)));
         tick;
         check_eq("rr_bubble", 32'(grant), 0);
         check_eq("rr_addr", 32'(mem_addr), 32'(100 + (k % 3)));
         check_eq("rr_data", 32'(mem_data), 32'('h111 * ((k % 3) + 1)));
      end
      bus.req_valid = '0;
      bus.req_last  = '0;

      // Burst cap: requester 1 streams with no last, requester 2 waiting
      set_req(1, 1'b1, 1'b0, 50, 'h0F0);
      set_req(2, 1'b1, 1'b1, 60, 'h00F);
      tick;
      check_eq("cap_grant1", 32'(grant), 2);
      n = 0;
      while (grant == 3'b010 && n < 200) begin
         n++;
         tick;
      end
      check_eq("cap_beats", 32'(n), 64);
      check_eq("cap_bubble", 32'(grant), 0);
      check_eq("cap_last_we", 32'(mem_we), 1);
      tick;
      check_eq("cap_grant2", 32'(grant), 4);
      tick;
      set_req(2, 1'b0, 1'b0, 0, 0);
      check_eq("cap_addr2", 32'(mem_addr), 60);
      tick;
      check_eq("cap_resume1", 32'(grant), 2);
      set_req(1, 1'b1, 1'b1, 51, 'h0F0);
      tick;
      set_req(1, 1'b0, 1'b0, 0, 0);
      check_eq("cap_end", 32'(grant), 0);

      // Vblank gating
      vblank = 1'b0;
      set_req(2, 1'b1, 1'b0, 200, 'h0AA);
      tick;
      check_eq("vb_grant", 32'(grant), 4);
      check_eq("vb_ready0", 32'(bus.req_ready), 0);
      tick;
      check_eq("vb_we0", 32'(mem_we), 0);
      vblank = 1'b1;
      writes = 0;
      for (int c = 0; c < 8; c++) begin
         tick;
         if (mem_we) writes++;
         if (c == 2) vblank = 1'b0;
      end
      check_eq("vb_writes", 32'(writes), 3);
      check_eq("vb_grant_held", 32'(grant), 4);
      check_eq("vb_ready_gap", 32'(bus.req_ready), 0);
      vblank = 1'b1;
      set_req(2, 1'b1, 1'b1, 201, 'h0AA);
      tick;
      set_req(2, 1'b0, 1'b0, 0, 0);
      check_eq("vb_end", 32'(grant), 0);

      // Out-of-range address
      set_req(0, 1'b1, 1'b1, 307200, 'h123);
      tick;
      check_eq("oor_ready", 32'(bus.req_ready), 1);
      tick;
      set_req(0, 1'b0, 1'b0, 0, 0);
      check_eq("oor_we", 32'(mem_we), 0);
      check_eq("oor_err", 32'(addr_err), 1);
      tick;
      tick;
      check_eq("oor_err_sticky", 32'(addr_err), 1);
      set_req(0, 1'b1, 1'b1, 307199, 'h0AB);
      tick;
      tick;
      set_req(0, 1'b0, 1'b0, 0, 0);
      check_eq("edge_we", 32'(mem_we), 1);
      check_eq("edge_addr", 32'(mem_addr), 307199);
      check_eq("edge_data", 32'(mem_data), 'h0AB);
      check_eq("edge_err", 32'(addr_err), 1);

      // Reset in the middle of a burst
      set_req(0, 1'b1, 1'b0, 10, 'h555);
      tick;
      check_eq("mid_grant", 32'(grant), 1);
      tick;
      tick;
      RESET_N = 1'b0;
      tick;
      RESET_N = 1'b1;
      set_req(0, 1'b0, 1'b0, 0, 0);
      check_eq("mid_grant_rst", 32'(grant), 0);
      check_eq("mid_busy_rst", 32'(busy), 0);
      check_eq("mid_we_rst", 32'(mem_we), 0);
      check_eq("mid_err_rst", 32'(addr_err), 0);
      set_req(0, 1'b1, 1'b1, 20, 'h321);
      set_req(2, 1'b1, 1'b1, 22, 'h654);
      tick;
      check_eq("mid_rr_zero", 32'(grant), 1);
      tick;
      set_req(0, 1'b0, 1'b0, 0, 0);
      tick;
      check_eq("mid_grant2", 32'(grant), 4);
      tick;
      set_req(2, 1'b0, 1'b0, 0, 0);
      check_eq("mid_done", 32'(grant), 0);
      check_eq("mid_we2", 32'(mem_we), 1);
      check_eq("mid_addr2", 32'(mem_addr), 22);
      check_eq("mid_data2", 32'(mem_data), 'h654);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
